// File: rtl/processor_control_fsm.sv
// Control unit for the bus-multiplexer processor: sequences T0..T3 for mv, mvi, add and sub
// and produces the one-hot bus select plus register/ALU load enables.
module processor_control_fsm (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Run,
   input  logic [15:0] DIN,
   output logic [9:0]  control,
   output logic [7:0]  Rin,
   output logic        Ain,
   output logic        Gin,
   output logic        AddSub,
   output logic        IRin,
   output logic        Done
);

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

   state_e     state_q, state_d;
   logic [8:0] ir_q, ir_d;
   logic [2:0] opcode, xxx, yyy;

   // Only the low nine bits of DIN form an instruction word.
   logic unused_din;
   assign unused_din = ^DIN[15:9];

   assign opcode = ir_q[8:6];
   assign xxx    = ir_q[5:3];
   assign yyy    = ir_q[2:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StT0;
         ir_q    <= 9'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = StT0;
      ir_d    = ir_q;
      control = 10'b0;
      Rin     = 8'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AddSub  = 1'b0;
      IRin    = 1'b0;
      Done    = 1'b0;

      case (state_q)
         StT0: begin
            IRin = Run;
            if (Run) begin
               ir_d    = DIN[8:0];
               state_d = StT1;
            end
         end
         StT1: begin
            case (opcode)
               OP_MV: begin
                  control[yyy] = 1'b1;
                  Rin[xxx]     = 1'b1;
                  Done         = 1'b1;
               end
               OP_MVI: begin
                  control[9] = 1'b1;
                  Rin[xxx]   = 1'b1;
                  Done       = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  control[xxx] = 1'b1;
                  Ain          = 1'b1;
                  state_d      = StT2;
               end
               // Opcodes 1xx complete as a NOP.
               default: Done = 1'b1;
            endcase
         end
         StT2: begin
            control[yyy] = 1'b1;
            Gin          = 1'b1;
            AddSub       = (opcode == OP_SUB);
            state_d      = StT3;
         end
         StT3: begin
            control[8] = 1'b1;
            Rin[xxx]   = 1'b1;
            Done       = 1'b1;
         end
         default: state_d = StT0;
      endcase

      // Outputs are combinational, so gate them while reset is held to keep IRin quiet.
      if (Reset) begin
         control = 10'b0;
         Rin     = 8'b0;
         Ain     = 1'b0;
         Gin     = 1'b0;
         AddSub  = 1'b0;
         IRin    = 1'b0;
         Done    = 1'b0;
      end
   end

endmodule

// File: tb/tb_processor_control_fsm.sv
// Directed self-checking bench for processor_control_fsm: walks each instruction class step
// by step and compares all outputs against hand-computed vectors.
module tb_processor_control_fsm;

   logic        Clock;
   logic        Reset;
   logic        Run;
   logic [15:0] DIN;
   logic [9:0]  control;
   logic [7:0]  Rin;
   logic        Ain, Gin, AddSub, IRin, Done;

   int errors = 0;
   int checks = 0;

   processor_control_fsm dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Run     (Run),
      .DIN     (DIN),
      .control (control),
      .Rin     (Rin),
      .Ain     (Ain),
      .Gin     (Gin),
      .AddSub  (AddSub),
      .IRin    (IRin),
      .Done    (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [22:0] ZERO = 23'b0;

   // Output vector layout: {control, Rin, Ain, Gin, AddSub, IRin, Done}.
   function automatic logic [22:0] pk(input logic [9:0] c, input logic [7:0] r, input logic a,
                                      input logic g, input logic s, input logic ir,
                                      input logic d);
      return {c, r, a, g, s, ir, d};
   endfunction

   task automatic chk(input string tag, input logic [22:0] exp);
      logic [22:0] obs;
      #1;
      obs = {control, Rin, Ain, Gin, AddSub, IRin, Done};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed control=%h Rin=%h A/G/S/IR/D=%b expected control=%h Rin=%h A/G/S/IR/D=%b",
                tag, obs[22:13], obs[12:5], obs[4:0], exp[22:13], exp[12:5], exp[4:0]);
      end
   endtask

   task automatic next();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b1;
      DIN   = 16'h0058;
      chk("reset_run_high", ZERO);
      Run = 1'b0;
      DIN = 16'h0000;
      next();
      next();
      chk("reset_held", ZERO);
      Reset = 1'b0;
      chk("reset_release", ZERO);
      for (int i = 0; i < 5; i++) begin
         next();
         chk("idle_run_low", ZERO);
      end

      // mvi R3
      Run = 1'b1;
      DIN = 16'h0058;
      chk("mvi_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      DIN = 16'h0000;
      chk("mvi_t1", pk(10'h200, 8'h08, 0, 0, 0, 0, 1));
      next();
      chk("mvi_back_t0", ZERO);

      // mv R1,R6 with junk in DIN[15:9]
      Run = 1'b1;
      DIN = 16'hFE0E;
      chk("mv_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      DIN = 16'h0000;
      chk("mv_t1", pk(10'h040, 8'h02, 0, 0, 0, 0, 1));
      next();
      chk("mv_back_t0", ZERO);

      // sub R5,R2
      Run = 1'b1;
      DIN = 16'h00EA;
      chk("sub_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      DIN = 16'h0000;
      chk("sub_t1", pk(10'h020, 8'h00, 1, 0, 0, 0, 0));
      next();
      chk("sub_t2", pk(10'h004, 8'h00, 0, 1, 1, 0, 0));
      next();
      chk("sub_t3", pk(10'h100, 8'h20, 0, 0, 0, 0, 1));
      next();
      chk("sub_back_t0", ZERO);

      // add R2,R2 with Run held high, then mvi R7 queued behind it
      Run = 1'b1;
      DIN = 16'h0092;
      chk("add_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      DIN = 16'h0078;
      chk("add_t1", pk(10'h004, 8'h00, 1, 0, 0, 0, 0));
      next();
      chk("add_t2_run_ignored", pk(10'h004, 8'h00, 0, 1, 0, 0, 0));
      next();
      chk("add_t3", pk(10'h100, 8'h04, 0, 0, 0, 0, 1));
      next();
      chk("b2b_t0_irin", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      chk("b2b_mvi_r7_t1", pk(10'h200, 8'h80, 0, 0, 0, 0, 1));
      next();
      chk("b2b_back_t0", ZERO);

      // add R0,R1 aborted by reset in T2
      Run = 1'b1;
      DIN = 16'h0081;
      chk("abort_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      DIN = 16'h0000;
      chk("abort_t1", pk(10'h001, 8'h00, 1, 0, 0, 0, 0));
      next();
      chk("abort_t2", pk(10'h002, 8'h00, 0, 1, 0, 0, 0));
      Reset = 1'b1;
      chk("abort_reset_now", ZERO);
      next();
      chk("abort_reset_held", ZERO);
      Reset = 1'b0;
      chk("abort_released", ZERO);
      next();
      chk("abort_no_rin", ZERO);
      next();
      chk("abort_idle", ZERO);

      // Opcode 111 acts as a NOP
      Run = 1'b1;
      DIN = 16'h01DA;
      chk("nop_t0", pk(10'h000, 8'h00, 0, 0, 0, 1, 0));
      next();
      Run = 1'b0;
      DIN = 16'h0000;
      chk("nop_t1", pk(10'h000, 8'h00, 0, 0, 0, 0, 1));
      next();
      chk("nop_back_t0", ZERO);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
